psg_spi_write_bridge: RTL and testbench



---
 rtl/psg_spi_write_bridge.sv | 203 ++++++++++++++++++++
 tb/tb_psg_spi_write_bridge.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/psg_spi_write_bridge.sv
// psg_spi_write_bridge: SPI (mode 0, MSB first) byte receiver feeding a small
// FIFO, replayed onto the PSG parallel bus with a paced one-cycle write strobe.
// Optional status readback over spi_miso is enabled by defining PSG_SPI_STATUS_EN.
module psg_spi_write_bridge #(
  parameter int FIFO_DEPTH  = 4,
  parameter int WRITE_GAP   = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          spi_sck,
  input  logic                          spi_mosi,
  input  logic                          spi_cs_n,
  output logic [7:0]                    psg_data,
  output logic                          psg_we_n,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
`ifdef PSG_SPI_STATUS_EN
  output logic                          busy,
  output logic                          spi_miso
`else
  output logic                          busy
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int GAP_W = (WRITE_GAP > 2) ? $clog2(WRITE_GAP) : 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(WRITE_GAP - 2);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STROBE = 2'd1;
  localparam logic [1:0] ST_GAP    = 2'd2;

  logic [SYNC_STAGES-1:0] r_sck_sync, r_cs_sync, r_mosi_sync;
  logic                   r_sck_d, r_cs_d;
  logic [6:0]             r_shift;
  logic [2:0]             r_bit_cnt;
  logic [7:0]             r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr, r_rd_ptr;
  logic [LVL_W-1:0]       r_level;
  logic [1:0]             r_state;
  logic [GAP_W-1:0]       r_gap_cnt;
  logic [7:0]             r_psg_data;
  logic                   r_overflow;

  logic       w_sck, w_cs_n, w_mosi;
  logic       w_sck_rise, w_cs_rise;
  logic       w_push, w_pop, w_full, w_wr_en, w_drop;
  logic [7:0] w_rx_byte;

  assign w_sck      = r_sck_sync[SYNC_STAGES-1];
  assign w_cs_n     = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck & ~r_sck_d;
  assign w_cs_rise  = w_cs_n & ~r_cs_d;

  assign w_rx_byte  = {r_shift, w_mosi};
  assign w_push     = ~w_cs_n & w_sck_rise & (r_bit_cnt == 3'd7);
  assign w_pop      = (r_state == ST_IDLE) && (r_level != '0);
  assign w_full     = (r_level == FULL_LVL);
  // A full FIFO still accepts a push when the head is leaving this cycle.
  assign w_wr_en    = w_push & (~w_full | w_pop);
  assign w_drop     = w_push & w_full & ~w_pop;

  assign psg_data   = r_psg_data;
  assign psg_we_n   = (r_state != ST_STROBE);
  assign fifo_level = r_level;
  assign overflow   = r_overflow;
  assign busy       = (r_level != '0) || (r_state != ST_IDLE);

  // Synchronise the asynchronous SPI pins and keep a delayed copy for edges.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sck_sync  <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sck_d     <= 1'b0;
      r_cs_d      <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_sck_d     <= w_sck;
      r_cs_d      <= w_cs_n;
    end
  end

  // Shift in MOSI on each sck rise inside a frame; frame end drops partial bytes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (w_cs_rise) begin
      r_bit_cnt <= '0;
    end else if (~w_cs_n & w_sck_rise) begin
      r_shift   <= w_rx_byte[6:0];
      r_bit_cnt <= r_bit_cnt + 3'd1;
    end
  end

  // FIFO storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= w_rx_byte;
  end

  // FIFO pointers and occupancy; power-of-two depth makes pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_en, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Pacer: pop into psg_data, strobe one cycle, then hold off for the gap.
  // The IDLE cycle that pops the next byte counts toward the spacing, so the
  // gap state lasts WRITE_GAP-2 cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_gap_cnt  <= '0;
      r_psg_data <= 8'h00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_psg_data <= r_mem[r_rd_ptr];
            r_state    <= ST_STROBE;
          end
        end
        ST_STROBE: begin
          r_gap_cnt <= GAP_LOAD;
          r_state   <= (GAP_LOAD == '0) ? ST_IDLE : ST_GAP;
        end
        ST_GAP: begin
          r_gap_cnt <= r_gap_cnt - 1'b1;
          if (r_gap_cnt <= GAP_W'(1)) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef PSG_SPI_STATUS_EN
  logic [7:0] r_tx_sh;
  logic [3:0] r_tx_cnt;
  logic       r_stat_ovf;
  logic       w_sck_fall, w_cs_fall, w_ovf_clr;

  assign w_sck_fall = ~w_sck & r_sck_d;
  assign w_cs_fall  = ~w_cs_n & r_cs_d;
  // Overflow is acknowledged only once the host has clocked out a full status byte.
  assign w_ovf_clr  = w_cs_rise & r_stat_ovf & (r_tx_cnt == 4'd8);
  assign spi_miso   = ~w_cs_n & r_tx_sh[7];

  // Level field of the status byte is four bits wide.
  function automatic logic [3:0] lvl4(input logic [LVL_W-1:0] lvl);
    logic [7:0] t;
    t = 8'(lvl);
    return t[3:0];
  endfunction

  // Capture status at frame start and shift it out on sck falls, then zeros.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tx_sh    <= '0;
      r_tx_cnt   <= '0;
      r_stat_ovf <= 1'b0;
    end else if (w_cs_fall) begin
      r_tx_sh    <= {r_overflow, busy, 2'b00, lvl4(r_level)};
      r_tx_cnt   <= '0;
      r_stat_ovf <= r_overflow;
    end else if (~w_cs_n & w_sck_fall) begin
      r_tx_sh <= {r_tx_sh[6:0], 1'b0};
      if (r_tx_cnt != 4'd8) r_tx_cnt <= r_tx_cnt + 4'd1;
    end
  end
`endif

  // Sticky drop flag; a fresh drop always wins over an acknowledge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
`ifdef PSG_SPI_STATUS_EN
    end else if (w_ovf_clr) begin
      r_overflow <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_psg_spi_write_bridge.sv
// Directed bench for psg_spi_write_bridge: two instances share sck/mosi and
// have separate chip selects (A: WRITE_GAP=32, B: WRITE_GAP=300).
module tb_psg_spi_write_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, sck, mosi, cs_a, cs_b;
  logic [7:0] data_a, data_b;
  logic       we_a, we_b, ovf_a, ovf_b, busy_a, busy_b;
  logic [2:0] lvl_a, lvl_b;
`ifdef PSG_SPI_STATUS_EN
  logic       miso_a, miso_b;
`endif

  psg_spi_write_bridge #(.FIFO_DEPTH(4), .WRITE_GAP(32), .SYNC_STAGES(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .spi_sck(sck), .spi_mosi(mosi), .spi_cs_n(cs_a),
    .psg_data(data_a), .psg_we_n(we_a), .fifo_level(lvl_a), .overflow(ovf_a),
`ifdef PSG_SPI_STATUS_EN
    .spi_miso(miso_a),
`endif
    .busy(busy_a));

  psg_spi_write_bridge #(.FIFO_DEPTH(4), .WRITE_GAP(300), .SYNC_STAGES(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .spi_sck(sck), .spi_mosi(mosi), .spi_cs_n(cs_b),
    .psg_data(data_b), .psg_we_n(we_b), .fifo_level(lvl_b), .overflow(ovf_b),
`ifdef PSG_SPI_STATUS_EN
    .spi_miso(miso_b),
`endif
    .busy(busy_b));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;
  int r_last = 0;

  task automatic chk_val(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Strobe log and side monitors, sampled 1 time unit after each rising edge.
  logic [7:0] qa_d[$], qb_d[$];
  int         qa_c[$], qb_c[$];
  int         wide_a = 0, wide_b = 0, fall_a = -1, peak_b = 0;
  bit         mon_en = 0, pa = 0, pb = 0, ba = 0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (!we_a) begin qa_d.push_back(data_a); qa_c.push_back(cyc); if (pa) wide_a++; end
        if (!we_b) begin qb_d.push_back(data_b); qb_c.push_back(cyc); if (pb) wide_b++; end
        pa = !we_a;
        pb = !we_b;
        if (ba && !busy_a) fall_a = cyc;
        ba = busy_a;
        if (int'(lvl_b) > peak_b) peak_b = int'(lvl_b);
      end
    end
  end

  function automatic int dat(input int which, input int i);
    if (which == 0) return (i < qa_d.size()) ? int'(qa_d[i]) : -1;
    return (i < qb_d.size()) ? int'(qb_d[i]) : -1;
  endfunction

  function automatic int cy(input int which, input int i);
    if (which == 0) return (i < qa_c.size()) ? qa_c[i] : -100000;
    return (i < qb_c.size()) ? qb_c[i] : -100000;
  endfunction

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_set(input int sel, input logic v);
    if (sel == 0) cs_a = v; else cs_b = v;
  endtask

  // Send the top nbits of b, MSB first; sck half-period is 3 clk cycles.
  task automatic send_bits(input logic [7:0] b, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      mosi = b[7-i];
      wait_n(3);
      sck = 1'b1;
      r_last = cyc;
      wait_n(3);
      sck = 1'b0;
    end
  endtask

  task automatic frame1(input int sel, input logic [7:0] b);
    cs_set(sel, 1'b0);
    wait_n(3);
    send_bits(b, 8);
    wait_n(3);
    cs_set(sel, 1'b1);
    wait_n(3);
  endtask

  int r1, r2;

  initial begin
    rst_n = 1'b0; sck = 1'b0; mosi = 1'b0; cs_a = 1'b1; cs_b = 1'b1;
    wait_n(4);
    chk_val("rst_we_n",  int'(we_a),   1);
    chk_val("rst_data",  int'(data_a), 8'h00);
    chk_val("rst_level", int'(lvl_a),  0);
    chk_val("rst_ovf",   int'(ovf_a),  0);
    chk_val("rst_busy",  int'(busy_a), 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    wait_n(5);

    // Single byte
    frame1(0, 8'h9F);
    r1 = r_last;
    wait_n(60);
    chk_val("single_count",   qa_d.size(), 1);
    chk_val("single_data",    dat(0, 0), 8'h9F);
    chk_val("single_latency", cy(0, 0) - r1, 4);
    chk_val("single_level",   int'(lvl_a), 0);
    chk_val("busy_fall",      fall_a - cy(0, 0), 31);
    chk_val("busy_idle",      int'(busy_a), 0);

    // Two bytes in one frame
    cs_a = 1'b0;
    wait_n(3);
    send_bits(8'h8E, 8);
    r1 = r_last;
    send_bits(8'h03, 8);
    r2 = r_last;
    wait_n(3);
    cs_a = 1'b1;
    wait_n(100);
    chk_val("burst_count",   qa_d.size(), 3);
    chk_val("burst_data0",   dat(0, 1), 8'h8E);
    chk_val("burst_data1",   dat(0, 2), 8'h03);
    chk_val("burst_latency", cy(0, 1) - r1, 4);
    chk_val("burst_spacing", cy(0, 2) - cy(0, 1), 48);
    chk_val("burst_lat2",    cy(0, 2) - r2, 4);

    // Partial byte then full frame
    cs_a = 1'b0;
    wait_n(3);
    send_bits(8'hFF, 5);
    wait_n(3);
    cs_a = 1'b1;
    wait_n(20);
    chk_val("partial_none", qa_d.size(), 3);
    frame1(0, 8'hE4);
    wait_n(60);
    chk_val("partial_count", qa_d.size(), 4);
    chk_val("partial_data",  dat(0, 3), 8'hE4);
    chk_val("pulse_width_a", wide_a, 0);

    // Overflow on the slow-paced instance
    peak_b = 0;
    cs_b = 1'b0;
    wait_n(3);
    send_bits(8'h01, 8);
    r1 = r_last;
    for (int k = 2; k <= 6; k++) send_bits(8'(k), 8);
    wait_n(3);
    cs_b = 1'b1;
    wait_n(3);
    chk_val("ovf_flag",     int'(ovf_b), 1);
    chk_val("ovf_level",    int'(lvl_b), 4);
    chk_val("ovf_peak",     peak_b, 4);
    wait_n(1300);
    chk_val("ovf_count",    qb_d.size(), 5);
    for (int k = 0; k < 5; k++) chk_val($sformatf("ovf_data%0d", k), dat(1, k), k + 1);
    chk_val("ovf_latency",  cy(1, 0) - r1, 4);
    chk_val("ovf_spacing",  cy(1, 2) - cy(1, 1), 300);
    chk_val("ovf_drained",  int'(lvl_b), 0);
    chk_val("ovf_sticky",   int'(ovf_b), 1);
    chk_val("pulse_width_b", wide_b, 0);

    // Reset while three bytes are buffered and the pacer is in its gap
    cs_b = 1'b0;
    wait_n(3);
    send_bits(8'h11, 8);
    send_bits(8'h22, 8);
    send_bits(8'h33, 8);
    send_bits(8'h44, 8);
    wait_n(3);
    cs_b = 1'b1;
    wait_n(10);
    chk_val("pre_rst_level", int'(lvl_b), 3);
    chk_val("pre_rst_data",  int'(data_b), 8'h11);
    chk_val("pre_rst_we_n",  int'(we_b), 1);
    rst_n = 1'b0;
    wait_n(1);
    rst_n = 1'b1;
    chk_val("mid_rst_we_n",  int'(we_b), 1);
    chk_val("mid_rst_data",  int'(data_b), 8'h00);
    chk_val("mid_rst_level", int'(lvl_b), 0);
    chk_val("mid_rst_ovf",   int'(ovf_b), 0);
    chk_val("mid_rst_busy",  int'(busy_b), 0);
    wait_n(700);
    chk_val("post_rst_count", qb_d.size(), 6);
    chk_val("post_rst_busy",  int'(busy_b), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
